// File: rtl/shift_pipe_if.sv
// shift_pipe_if: valid/ready operand and result bus of the shift/rotate unit.
//   in_valid/in_ready   operation handshake (in_ready driven by the unit)
//   in_data             operand, WIDTH bits
//   in_amount           unsigned shift/rotate count, AMT_W bits
//   in_mode             000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, else pass
//   out_valid/out_ready result handshake (out_ready driven by the consumer)
//   out_data            result, WIDTH bits
//   out_carry/out_zero  result flags, present only with SHIFT_PIPE_FLAGS_EN
// master = issuing side (ALU / bench), slave = shift_pipe.
interface shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amount;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SHIFT_PIPE_FLAGS_EN
    logic             out_carry;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_amount, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );
    modport slave (
        input  in_valid, in_data, in_amount, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );
`else
    modport master (
        output in_valid, in_data, in_amount, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_amount, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter / rotator, WIDTH a power of two >= 4.
//   clock    rising-edge clock
//   clear_n  asynchronous active-low reset
//   bus      shift_pipe_if.slave (operand in, result out, valid/ready both sides)
// Structure: a capture register (stage 0) fixes the effective amount, the
// saturation result and the fill sign at acceptance; stages 1..S each
// conditionally shift by 2^(k-1). Result sits in stage S, so a result is
// presented S cycles after the acceptance edge.
// The whole pipe, bubbles included, advances on adv = !out_valid || out_ready.
// Optional feature macro: SHIFT_PIPE_FLAGS_EN adds out_carry and out_zero.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32
) (
    input logic       clock,
    input logic       clear_n,
    shift_pipe_if.slave bus
);
    localparam int S  = $clog2(WIDTH);
    // Wide enough to compare any in_amount against WIDTH without truncation.
    localparam int CW = AMT_W + S + 2;

    localparam logic [2:0] M_SHR  = 3'd0;
    localparam logic [2:0] M_SHRA = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_ROR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;

    logic [S:0]            vld_pipe;
    logic [S:0][WIDTH-1:0] data_pipe;
    logic [S:0][S-1:0]     amt_pipe;
    logic [S:0][2:0]       mode_pipe;
    logic [S:0]            sign_pipe;

    logic adv;
    assign adv          = !vld_pipe[S] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld_pipe[S];
    assign bus.out_data  = data_pipe[S];

    // ---------------- capture (stage 0) ----------------
    logic [CW-1:0]    amt_wide;
    logic             saturate;
    logic [WIDTH-1:0] cap_data;
    logic [S-1:0]     cap_amt;
    logic [2:0]       cap_mode;

    assign amt_wide = CW'(bus.in_amount);
    assign saturate = amt_wide >= CW'(WIDTH);

    // Saturated shifts and pass-through are resolved here with amount 0, so
    // the stages only ever see in-range shifts or rotates.
    always_comb begin
        cap_data = bus.in_data;
        cap_amt  = amt_wide[S-1:0];
        cap_mode = bus.in_mode;
        case (bus.in_mode)
            M_SHR, M_SHRA, M_SHL: begin
                if (saturate) begin
                    cap_amt  = '0;
                    cap_data = (bus.in_mode == M_SHRA && bus.in_data[WIDTH-1]) ? '1 : '0;
                end
            end
            M_ROR, M_ROL: begin
                cap_amt = amt_wide[S-1:0];
            end
            default: begin
                cap_amt  = '0;
                cap_mode = M_SHR;
            end
        endcase
    end

    logic             cap_vld_q;
    logic [WIDTH-1:0] cap_data_q;
    logic [S-1:0]     cap_amt_q;
    logic [2:0]       cap_mode_q;
    logic             cap_sign_q;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cap_vld_q  <= 1'b0;
            cap_data_q <= '0;
            cap_amt_q  <= '0;
            cap_mode_q <= '0;
            cap_sign_q <= 1'b0;
        end else if (adv) begin
            cap_vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                cap_data_q <= cap_data;
                cap_amt_q  <= cap_amt;
                cap_mode_q <= cap_mode;
                cap_sign_q <= bus.in_data[WIDTH-1];
            end
        end
    end

    assign vld_pipe[0]  = cap_vld_q;
    assign data_pipe[0] = cap_data_q;
    assign amt_pipe[0]  = cap_amt_q;
    assign mode_pipe[0] = cap_mode_q;
    assign sign_pipe[0] = cap_sign_q;

`ifdef SHIFT_PIPE_FLAGS_EN
    // ---------------- carry at acceptance ----------------
    logic [S:0]   carry_pipe;
    logic         zero_q;
    logic         over;
    logic [S-1:0] idx_r;
    logic [S-1:0] idx_l;
    logic         cap_carry;
    logic         cap_carry_q;

    assign over  = amt_wide > CW'(WIDTH);
    // Right ops lose bit n-1 last; left ops lose bit WIDTH-n. Both wrap mod
    // WIDTH, which is exactly what rotates need for their last moved bit.
    assign idx_r = amt_wide[S-1:0] - S'(1);
    assign idx_l = S'(0) - amt_wide[S-1:0];

    always_comb begin
        cap_carry = 1'b0;
        if (amt_wide != '0) begin
            case (bus.in_mode)
                M_SHR, M_SHRA: begin
                    if (!over) cap_carry = bus.in_data[idx_r];
                    else       cap_carry = (bus.in_mode == M_SHRA) && bus.in_data[WIDTH-1];
                end
                M_SHL: begin
                    if (!over) cap_carry = bus.in_data[idx_l];
                end
                M_ROR:   cap_carry = bus.in_data[idx_r];
                M_ROL:   cap_carry = bus.in_data[idx_l];
                default: cap_carry = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)                  cap_carry_q <= 1'b0;
        else if (adv && bus.in_valid)  cap_carry_q <= cap_carry;
    end

    assign carry_pipe[0] = cap_carry_q;
    assign bus.out_carry = carry_pipe[S];
    assign bus.out_zero  = zero_q;
`endif

    // ---------------- shift stages 1..S ----------------
    for (genvar k = 1; k <= S; k++) begin : g_stage
        localparam int D = 1 << (k - 1);

        logic             vld_q;
        logic [WIDTH-1:0] data_q;
        logic [S-1:0]     amt_q;
        logic [2:0]       mode_q;
        logic             sign_q;
        logic [WIDTH-1:0] shifted;
        logic [WIDTH-1:0] nxt;

        always_comb begin
            shifted = data_pipe[k-1];
            case (mode_pipe[k-1])
                M_SHR:   shifted = data_pipe[k-1] >> D;
                M_SHRA:  shifted = {{D{sign_pipe[k-1]}}, data_pipe[k-1][WIDTH-1:D]};
                M_SHL:   shifted = data_pipe[k-1] << D;
                M_ROR:   shifted = {data_pipe[k-1][D-1:0], data_pipe[k-1][WIDTH-1:D]};
                M_ROL:   shifted = {data_pipe[k-1][WIDTH-D-1:0], data_pipe[k-1][WIDTH-1:WIDTH-D]};
                default: shifted = data_pipe[k-1];
            endcase
            nxt = amt_pipe[k-1][k-1] ? shifted : data_pipe[k-1];
        end

        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                amt_q  <= '0;
                mode_q <= '0;
                sign_q <= 1'b0;
            end else if (adv) begin
                vld_q  <= vld_pipe[k-1];
                data_q <= nxt;
                amt_q  <= amt_pipe[k-1];
                mode_q <= mode_pipe[k-1];
                sign_q <= sign_pipe[k-1];
            end
        end

        assign vld_pipe[k]  = vld_q;
        assign data_pipe[k] = data_q;
        assign amt_pipe[k]  = amt_q;
        assign mode_pipe[k] = mode_q;
        assign sign_pipe[k] = sign_q;

`ifdef SHIFT_PIPE_FLAGS_EN
        logic carry_q;
        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n)  carry_q <= 1'b0;
            else if (adv)  carry_q <= carry_pipe[k-1];
        end
        assign carry_pipe[k] = carry_q;

        // Zero flag is registered alongside the final data word.
        if (k == S) begin : g_last
            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n)  zero_q <= 1'b0;
                else if (adv)  zero_q <= (nxt == '0);
            end
        end
`endif
    end

    // Control fields of the last stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{amt_pipe[S], mode_pipe[S], sign_pipe[S]};

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed table, hand sequences (backpressure, mid-stream
// reset, WIDTH=8 instance) and random traffic checked by a queue scoreboard
// fed from an arithmetic reference model.
module tb_shift_pipe;
    logic clock = 1'b0;
    logic clear_n;
    always #5 clock = ~clock;

    shift_pipe_if #(.WIDTH(32), .AMT_W(32)) bus32 ();
    shift_pipe_if #(.WIDTH(8),  .AMT_W(6))  bus8 ();

    shift_pipe #(.WIDTH(32), .AMT_W(32)) dut32 (.clock(clock), .clear_n(clear_n), .bus(bus32));
    shift_pipe #(.WIDTH(8),  .AMT_W(6))  dut8  (.clock(clock), .clear_n(clear_n), .bus(bus8));

    int errors = 0;
    int checks = 0;
    int out_count = 0;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] data;
        logic [31:0] amt;
        logic [31:0] exp_data;
        logic        exp_carry;
        logic        exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on a w-bit value held in 64 bits.
    function automatic logic [63:0] ref_shift(input int w, input logic [63:0] d_in,
                                              input longint unsigned n, input logic [2:0] m);
        logic [63:0] mask, d, r;
        int          rr;
        logic        sgn;
        mask = (64'd1 << w) - 64'd1;
        d    = d_in & mask;
        sgn  = d[w-1];
        rr   = int'(n % longint'(w));
        case (m)
            3'd0: r = (n >= longint'(w)) ? 64'd0 : (d >> n);
            3'd1: begin
                if (n >= longint'(w)) r = sgn ? mask : 64'd0;
                else begin
                    r = d >> n;
                    if (sgn) r = r | (mask & ~(mask >> n));
                end
            end
            3'd2: r = (n >= longint'(w)) ? 64'd0 : ((d << n) & mask);
            3'd3: r = ((d >> rr) | (d << (w - rr))) & mask;
            3'd4: r = ((d << rr) | (d >> (w - rr))) & mask;
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic ref_carry(input int w, input logic [63:0] d_in,
                                       input longint unsigned n, input logic [2:0] m);
        logic [63:0] d, res, t;
        d = d_in & ((64'd1 << w) - 64'd1);
        if (n == 0 || m > 3'd4) return 1'b0;
        res = ref_shift(w, d, n, m);
        case (m)
            3'd0, 3'd1: begin
                if (n <= longint'(w)) begin t = d >> (n - 1); return t[0]; end
                return (m == 3'd1) ? d[w-1] : 1'b0;
            end
            3'd2: begin
                if (n <= longint'(w)) begin t = d >> (longint'(w) - n); return t[0]; end
                return 1'b0;
            end
            3'd3: return res[w-1];
            default: return res[0];
        endcase
    endfunction

    // Scoreboard monitor, sampled mid-cycle.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clock) begin
        exp_t        e;
        logic [63:0] r;
        if (!clear_n) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 64'(bus32.in_ready), 64'(!bus32.out_valid || bus32.out_ready));
            if (prev_stall) begin
                check("hold_valid", 64'(bus32.out_valid), 64'd1);
                check("hold_data", 64'(bus32.out_data), 64'(prev_data));
            end
            if (bus32.out_valid && bus32.out_ready) begin
                out_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_spurious: got %0h want nothing", bus32.out_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 64'(bus32.out_data), 64'(e.data));
`ifdef SHIFT_PIPE_FLAGS_EN
                    check("sb_carry", 64'(bus32.out_carry), 64'(e.carry));
                    check("sb_zero", 64'(bus32.out_zero), 64'(e.zero));
`endif
                end
            end
            if (bus32.in_valid && bus32.in_ready) begin
                r       = ref_shift(32, 64'(bus32.in_data), longint'(bus32.in_amount), bus32.in_mode);
                e.data  = r[31:0];
                e.carry = ref_carry(32, 64'(bus32.in_data), longint'(bus32.in_amount), bus32.in_mode);
                e.zero  = (r == 64'd0);
                sb.push_back(e);
            end
            prev_stall = bus32.out_valid && !bus32.out_ready;
            prev_data  = bus32.out_data;
        end
    end

    task automatic run32(input logic [2:0] m, input logic [31:0] d, input logic [31:0] a,
                         output logic [31:0] res, output logic c, output logic z, output int lat);
        @(posedge clock); #1;
        bus32.in_valid = 1'b1; bus32.in_data = d; bus32.in_amount = a; bus32.in_mode = m;
        bus32.out_ready = 1'b1;
        @(posedge clock); #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        while (!bus32.out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        res = bus32.out_data;
`ifdef SHIFT_PIPE_FLAGS_EN
        c = bus32.out_carry; z = bus32.out_zero;
`else
        c = 1'b0; z = 1'b0;
`endif
    endtask

    task automatic run8(input logic [2:0] m, input logic [7:0] d, input logic [5:0] a,
                        output logic [7:0] res, output int lat);
        @(posedge clock); #1;
        bus8.in_valid = 1'b1; bus8.in_data = d; bus8.in_amount = a; bus8.in_mode = m;
        bus8.out_ready = 1'b1;
        @(posedge clock); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        res = bus8.out_data;
    endtask

    vec_t vt[16];

    initial begin
        logic [31:0] res;
        logic [7:0]  res8;
        logic        c, z;
        int          lat, base, cyc, i;
        logic [2:0]  om[10];
        logic [31:0] od[10], oa[10];
        logic [63:0] r;
        bit          seen;

        vt[0]  = '{3'd3, 32'h80000001, 32'd1,  32'hC0000000, 1'b1, 1'b0};
        vt[1]  = '{3'd3, 32'h80000001, 32'd33, 32'hC0000000, 1'b1, 1'b0};
        vt[2]  = '{3'd3, 32'h80000001, 32'd32, 32'h80000001, 1'b1, 1'b0};
        vt[3]  = '{3'd4, 32'h12345678, 32'd8,  32'h34567812, 1'b0, 1'b0};
        vt[4]  = '{3'd2, 32'h00000001, 32'd31, 32'h80000000, 1'b0, 1'b0};
        vt[5]  = '{3'd2, 32'h00000001, 32'd32, 32'h00000000, 1'b1, 1'b1};
        vt[6]  = '{3'd1, 32'h80000000, 32'd4,  32'hF8000000, 1'b0, 1'b0};
        vt[7]  = '{3'd1, 32'h80000000, 32'd40, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[8]  = '{3'd0, 32'h80000000, 32'd4,  32'h08000000, 1'b0, 1'b0};
        vt[9]  = '{3'd0, 32'h80000000, 32'd0,  32'h80000000, 1'b0, 1'b0};
        vt[10] = '{3'd5, 32'hDEADBEEF, 32'd5,  32'hDEADBEEF, 1'b0, 1'b0};
        vt[11] = '{3'd0, 32'h00000018, 32'd4,  32'h00000001, 1'b1, 1'b0};
        vt[12] = '{3'd2, 32'h80000000, 32'd1,  32'h00000000, 1'b1, 1'b1};
        vt[13] = '{3'd4, 32'h80000001, 32'd1,  32'h00000003, 1'b1, 1'b0};
        vt[14] = '{3'd1, 32'h7FFFFFFF, 32'd32, 32'h00000000, 1'b0, 1'b1};
        vt[15] = '{3'd1, 32'h80000000, 32'd32, 32'hFFFFFFFF, 1'b1, 1'b0};

        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_amount = '0; bus32.in_mode = '0;
        bus32.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_amount = '0; bus8.in_mode = '0;
        bus8.out_ready = 1'b1;
        clear_n = 1'b0;

        #2;
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_out_data", 64'(bus32.out_data), 64'd0);
        check("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        check("rst8_out_valid", 64'(bus8.out_valid), 64'd0);
        repeat (2) @(posedge clock);
        #1 clear_n = 1'b1;

        // Directed table
        for (int k = 0; k < 16; k++) begin
            run32(vt[k].mode, vt[k].data, vt[k].amt, res, c, z, lat);
            check($sformatf("vec%0d_latency", k), 64'(lat), 64'd5);
            check($sformatf("vec%0d_data", k), 64'(res), 64'(vt[k].exp_data));
`ifdef SHIFT_PIPE_FLAGS_EN
            check($sformatf("vec%0d_carry", k), 64'(c), 64'(vt[k].exp_carry));
            check($sformatf("vec%0d_zero", k), 64'(z), 64'(vt[k].exp_zero));
`endif
        end

        // WIDTH=8 instance
        run8(3'd3, 8'h81, 6'd1, res8, lat);
        check("w8_ror_latency", 64'(lat), 64'd3);
        check("w8_ror_data", 64'(res8), 64'hC0);
        run8(3'd6, 8'hA5, 6'd3, res8, lat);
        check("w8_pass_data", 64'(res8), 64'hA5);
        for (int k = 0; k < 20; k++) begin
            logic [2:0] m8;
            logic [7:0] d8;
            logic [5:0] a8;
            m8 = 3'($urandom_range(0, 7));
            d8 = 8'($urandom);
            a8 = 6'($urandom);
            run8(m8, d8, a8, res8, lat);
            r = ref_shift(8, 64'(d8), longint'(a8), m8);
            check($sformatf("w8_rand%0d_m%0d_a%0d", k, m8, a8), 64'(res8), r);
        end
        @(posedge clock); #1;

        // Backpressure: 10 back-to-back ops, out_ready low for 6 cycles
        for (int k = 0; k < 10; k++) begin
            om[k] = 3'($urandom_range(0, 4));
            od[k] = $urandom;
            oa[k] = 32'($urandom_range(0, 40));
        end
        base = out_count;
        i = 0;
        cyc = 0;
        while (i < 10 && cyc < 100) begin
            @(posedge clock); #1;
            bus32.out_ready = !(cyc >= 5 && cyc < 11);
            bus32.in_valid  = 1'b1;
            bus32.in_data   = od[i];
            bus32.in_amount = oa[i];
            bus32.in_mode   = om[i];
            @(negedge clock);
            if (bus32.in_ready) i++;
            cyc++;
        end
        check("bp_all_issued", 64'(i), 64'd10);
        @(posedge clock); #1;
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        cyc = 0;
        while (out_count - base < 10 && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("bp_out_count", 64'(out_count - base), 64'd10);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Random traffic with random backpressure
        base = out_count;
        for (int k = 0; k < 400; k++) begin
            @(posedge clock); #1;
            bus32.in_valid  = ($urandom_range(0, 3) != 0);
            bus32.in_mode   = 3'($urandom_range(0, 7));
            bus32.in_data   = $urandom;
            case ($urandom_range(0, 3))
                0: bus32.in_amount = 32'($urandom_range(0, 31));
                1: bus32.in_amount = 32'd32;
                2: bus32.in_amount = 32'($urandom_range(33, 70));
                default: bus32.in_amount = $urandom;
            endcase
            bus32.out_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clock); #1;
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("rand_sb_drained", 64'(sb.size()), 64'd0);

        // Reset with 3 operations in flight
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            bus32.in_valid = 1'b1; bus32.in_mode = 3'd2;
            bus32.in_data = 32'h0F0F0F0F + 32'(k); bus32.in_amount = 32'd1;
        end
        @(posedge clock); #1;
        bus32.in_valid = 1'b0;
        @(posedge clock); #1;
        clear_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("mid_rst_out_data", 64'(bus32.out_data), 64'd0);
        check("mid_rst_in_ready", 64'(bus32.in_ready), 64'd1);
`ifdef SHIFT_PIPE_FLAGS_EN
        check("mid_rst_carry", 64'(bus32.out_carry), 64'd0);
        check("mid_rst_zero", 64'(bus32.out_zero), 64'd0);
`endif
        sb.delete();
        @(posedge clock); #1;
        clear_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (bus32.out_valid) seen = 1'b1;
        end
        check("no_stale_result", 64'(seen), 64'd0);
        run32(3'd3, 32'h80000001, 32'd1, res, c, z, lat);
        check("post_rst_latency", 64'(lat), 64'd5);
        check("post_rst_data", 64'(res), 64'hC0000000);
        @(posedge clock); #1;
        @(posedge clock); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
